actor_dir_ctrl: RTL and testbench
=================================

# actor_dir_ctrl

Parametrised, multi-actor movement-direction controller for the maze game. For each of `NUM_ACTORS` actors (Pac-Man on channel 0, ghosts or a second player on the others), it buffers a requested direction and commits it at tile alignment when no wall blocks it. Mid-tile reversal is immediate, and an unused request expires after a programmable hold time. It sits between the input decoders (keyboard decoder, ghost AI) and the sprite position updaters, which consume `direction`.

## Interface
- `NUM_ACTORS`, 4: number of independent actor channels.
- `COORD_W`, 10: pixel-coordinate width.
- `TILE_BITS`, 4: log2 of tile size in pixels (16-pixel tiles).
- `QUEUE_HOLD`, 32: cycles a queued request survives unconsumed; 0 means it never expires.
- `Clk`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `Restart`  in  1  synchronous clear, same effect as reset.
- `cmd_valid`  in  NUM_ACTORS  per-actor request strobe.
- `cmd_dir`  in  3*NUM_ACTORS  per-actor requested direction, dir_t encoding.
- `pos_x`, `pos_y`  in  COORD_W*NUM_ACTORS  current actor pixel position.
- `walls`  in  4*NUM_ACTORS  per actor: bit0 up, bit1 right, bit2 down, bit3 left; 1 means a wall is in the adjacent tile.
- `direction`  out  3*NUM_ACTORS  committed direction, registered.
- `turned`  out  NUM_ACTORS  one-cycle pulse when a queued request is committed.
- `blocked`  out  NUM_ACTORS  level; high while the actor is stopped by a wall ahead.

## Operation
- dir_t encoding: STOP=000, UP=100, RIGHT=101, DOWN=110, LEFT=111. Other codes are treated as STOP.
- Opposite of a moving direction d is {1, ~d[1], d[0]}.
- Per actor, registers: `dir`, `q_dir`, `q_valid`, `q_age`, `blocked`.
- **Load.** When cmd_valid=1, set q_dir←cmd_dir, q_valid←1, q_age←0. A load wins over a same-cycle consume or expiry.
- **Expiry.** While q_valid=1 and no load is occurring, q_age increments. When QUEUE_HOLD≠0 and q_age reaches QUEUE_HOLD−1, q_valid clears. q_age saturates and does not wrap.
- **Aligned** means pos_x[TILE_BITS-1:0]==0 and pos_y[TILE_BITS-1:0]==0.
- Decision uses the registered q_dir and q_valid, evaluated in priority order:
  1. q_valid, and q_dir is opposite of a moving dir (alignment not required): dir←q_dir, consume, turned=1, blocked←0.
  2. Aligned, q_valid, q_dir=STOP: dir←STOP, consume, turned=1, blocked←0.
  3. Aligned, q_valid, q_dir moving, and wall bit for q_dir=0: dir←q_dir, consume, turned=1, blocked←0.
  4. Aligned, dir moving, and wall bit for dir=1: dir←STOP, blocked←1. The queue is retained.
  5. Otherwise, dir holds.
- Consume clears q_valid, unless a load occurs in the same cycle.
- When stopped and unblocked, the actor moves only through a valid request.
- Channels are fully independent; no shared arbitration.

## Timing
- Reset and Restart clear every register: direction=000, turned=0, blocked=0, q_valid=0, q_age=0.
- Reset is asynchronous. Restart takes effect on the next Clk edge and overrides cmd_valid in that cycle.
- Latency from a cmd_valid cycle N to a direction change is edge N+2 at the earliest: queue at N+1, decision at N+2.
- `turned` is registered and asserted in the same cycle the new direction appears.
- A reversal mid-tile takes effect at N+2 regardless of alignment.
- A request that arrives while blocked commits at N+2 if its wall bit is 0.
- `walls` and positions are sampled combinationally in the decision cycle. Upstream holds them stable for the whole aligned cycle.
- Reset asserted mid-operation drops any pending request; no request survives it.

## Structure
- Package `game_pkg`: dir_t enum, an `opposite()` function, and a `wall_bit(dir_t, walls)` function.
- Sub-module `actor_dir_unit` holds one channel's registers and decision logic.
- The top level slices the buses and instantiates `actor_dir_unit` NUM_ACTORS times in a generate loop.

## Test plan
- **Reset.** Assert Reset mid-run with q_valid=1 → direction=000, blocked=0, turned=0 immediately. After release, with no cmd, direction stays 000.
- **Aligned turn.** Actor0 moving RIGHT at (32,48), walls=0000; cmd UP at cycle N → direction=100 and turned=1 at N+2. turned=0 at N+3.
- **Wall stop.** Actor1 moving UP reaches (64,16) with walls=0001 → direction=000 and blocked=1 on the next edge. With cmd LEFT and walls=0001 → direction=111 two cycles later, blocked=0.
- **Mid-tile reverse and deferred turn.**
  - At (35,48) moving RIGHT, cmd LEFT → direction=111 at N+2, no alignment needed.
  - At (35,48), cmd DOWN → no change until x=48. Commits DOWN at that aligned cycle if walls[2]=0.
- **Expiry, QUEUE_HOLD=8.** Aligned, moving RIGHT, cmd UP with walls[0]=1 held for 10 cycles, then walls=0000 at the next tile → no turn, direction stays 101. Repeat with walls cleared at cycle 5 → turn taken.
- **Simultaneous events.**
  - cmd DOWN on actor2 in the same cycle its queued UP is consumed → next queue holds DOWN, q_valid=1.
  - Requests on actors 0 and 3 in the same cycle → both commit independently.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and helpers for the maze-game movement logic.
//   dir_t      : 3-bit direction code, STOP or one of four moving directions
//   to_dir()   : maps a raw 3-bit code onto dir_t; unknown codes become STOP
//   is_moving(): true for any direction other than STOP
//   opposite() : reverse of a moving direction
//   wall_bit() : selects the wall flag lying in the given direction
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        DIR_STOP  = 3'b000,
        DIR_UP    = 3'b100,
        DIR_RIGHT = 3'b101,
        DIR_DOWN  = 3'b110,
        DIR_LEFT  = 3'b111
    } dir_t;

    // Codes 001..011 are not directions; they are folded onto STOP so that
    // nothing downstream ever sees an illegal value.
    function automatic dir_t to_dir(input logic [2:0] raw);
        dir_t d;
        case (raw)
            3'b100:  d = DIR_UP;
            3'b101:  d = DIR_RIGHT;
            3'b110:  d = DIR_DOWN;
            3'b111:  d = DIR_LEFT;
            default: d = DIR_STOP;
        endcase
        return d;
    endfunction

    function automatic logic is_moving(input dir_t d);
        return d[2];
    endfunction

    // Reversal flips the vertical/horizontal half bit and keeps the axis bit.
    // Only meaningful for moving directions; callers qualify with is_moving().
    function automatic dir_t opposite(input dir_t d);
        return dir_t'({1'b1, ~d[1], d[0]});
    endfunction

    // walls: bit0 up, bit1 right, bit2 down, bit3 left.
    function automatic logic wall_bit(input dir_t d, input logic [3:0] walls);
        logic w;
        case (d)
            DIR_UP:    w = walls[0];
            DIR_RIGHT: w = walls[1];
            DIR_DOWN:  w = walls[2];
            DIR_LEFT:  w = walls[3];
            default:   w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/actor_dir_unit.sv
// ---------------------------------------------------------------------------
// actor_dir_unit
// One actor channel: buffers a requested direction, commits it at tile
// alignment when no wall blocks it, reverses immediately mid-tile, stops
// the actor at a wall, and lets an unused request expire after QUEUE_HOLD
// cycles (QUEUE_HOLD = 0 keeps it forever).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   restart         synchronous clear, same effect as rst
//   cmd_valid       request strobe
//   cmd_dir         requested direction (dir_t code)
//   pos_x, pos_y    current pixel position
//   walls           wall flags around the actor (bit0 up .. bit3 left)
//   direction       committed direction (registered)
//   turned          one-cycle pulse when a queued request is committed
//   blocked         high while stopped by a wall ahead
// ---------------------------------------------------------------------------
module actor_dir_unit
    import game_pkg::*;
#(
    parameter int COORD_W    = 10,
    parameter int TILE_BITS  = 4,
    parameter int QUEUE_HOLD = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd_dir,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic [3:0]         walls,
    output logic [2:0]         direction,
    output logic               turned,
    output logic               blocked
);

    // Age counter just wide enough to hold QUEUE_HOLD-1; it saturates at
    // all-ones, which only matters when QUEUE_HOLD = 0 (no expiry).
    localparam int AGE_W = (QUEUE_HOLD > 2) ? $clog2(QUEUE_HOLD) : 1;
    localparam logic [AGE_W-1:0] AGE_LAST =
        (QUEUE_HOLD == 0) ? '0 : AGE_W'(QUEUE_HOLD - 1);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    dir_t             dir_q,     dir_d;
    dir_t             q_dir_q,   q_dir_d;
    logic             q_valid_q, q_valid_d;
    logic [AGE_W-1:0] q_age_q,   q_age_d;
    logic             blocked_q, blocked_d;
    logic             turned_q,  turned_d;

    logic aligned;
    logic consume;
    logic expire;

    // Only the low tile-offset bits decide alignment; the tile index bits are
    // the position updaters' business.
    logic unused_pos_hi;
    assign unused_pos_hi = ^{pos_x[COORD_W-1:TILE_BITS], pos_y[COORD_W-1:TILE_BITS]};

    assign aligned = (pos_x[TILE_BITS-1:0] == '0) && (pos_y[TILE_BITS-1:0] == '0);
    assign expire  = (QUEUE_HOLD != 0) && (q_age_q == AGE_LAST);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        dir_d     = dir_q;
        q_dir_d   = q_dir_q;
        q_valid_d = q_valid_q;
        q_age_d   = q_age_q;
        blocked_d = blocked_q;
        turned_d  = 1'b0;
        consume   = 1'b0;

        // Decision, in priority order, on the registered queue.
        if (q_valid_q && is_moving(dir_q) && (q_dir_q == opposite(dir_q))) begin
            // Reversal never waits for alignment.
            dir_d   = q_dir_q;
            consume = 1'b1;
        end else if (aligned && q_valid_q && (q_dir_q == DIR_STOP)) begin
            dir_d   = DIR_STOP;
            consume = 1'b1;
        end else if (aligned && q_valid_q && is_moving(q_dir_q) &&
                     !wall_bit(q_dir_q, walls)) begin
            dir_d   = q_dir_q;
            consume = 1'b1;
        end else if (aligned && is_moving(dir_q) && wall_bit(dir_q, walls)) begin
            // Stop at the wall but keep any queued request for later.
            dir_d     = DIR_STOP;
            blocked_d = 1'b1;
        end

        if (consume) begin
            turned_d  = 1'b1;
            blocked_d = 1'b0;
        end

        // Queue maintenance: a fresh load beats consume and expiry.
        if (cmd_valid) begin
            q_dir_d   = to_dir(cmd_dir);
            q_valid_d = 1'b1;
            q_age_d   = '0;
        end else if (q_valid_q) begin
            if (consume || expire) begin
                q_valid_d = 1'b0;
            end
            if (q_age_q != AGE_MAX) begin
                q_age_d = q_age_q + AGE_W'(1);
            end
        end

        // Restart clears everything, including a same-cycle request.
        if (restart) begin
            dir_d     = DIR_STOP;
            q_dir_d   = DIR_STOP;
            q_valid_d = 1'b0;
            q_age_d   = '0;
            blocked_d = 1'b0;
            turned_d  = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values; rst is in the sensitivity list, making it async.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q     <= DIR_STOP;
            q_dir_q   <= DIR_STOP;
            q_valid_q <= 1'b0;
            q_age_q   <= '0;
            blocked_q <= 1'b0;
            turned_q  <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            q_dir_q   <= q_dir_d;
            q_valid_q <= q_valid_d;
            q_age_q   <= q_age_d;
            blocked_q <= blocked_d;
            turned_q  <= turned_d;
        end
    end

    assign direction = dir_q;
    assign turned    = turned_q;
    assign blocked   = blocked_q;

endmodule

// File: rtl/actor_dir_ctrl.sv
// ---------------------------------------------------------------------------
// actor_dir_ctrl
// Multi-actor movement-direction controller. Each of NUM_ACTORS channels is
// an independent actor_dir_unit; this level only slices the packed buses.
// Channel 0 is Pac-Man, the rest are ghosts or a second player.
// Ports (per-actor fields packed with actor 0 in the LSBs):
//   Clk, Reset      clock, asynchronous active-high reset
//   Restart         synchronous clear of every channel
//   cmd_valid       [NUM_ACTORS]         request strobes
//   cmd_dir         [3*NUM_ACTORS]       requested directions
//   pos_x, pos_y    [COORD_W*NUM_ACTORS] pixel positions
//   walls           [4*NUM_ACTORS]       wall flags, bit0 up .. bit3 left
//   direction       [3*NUM_ACTORS]       committed directions
//   turned          [NUM_ACTORS]         commit pulses
//   blocked         [NUM_ACTORS]         stopped-by-wall levels
// ---------------------------------------------------------------------------
module actor_dir_ctrl
    import game_pkg::*;
#(
    parameter int NUM_ACTORS = 4,
    parameter int COORD_W    = 10,
    parameter int TILE_BITS  = 4,
    parameter int QUEUE_HOLD = 32
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Restart,
    input  logic [NUM_ACTORS-1:0]         cmd_valid,
    input  logic [3*NUM_ACTORS-1:0]       cmd_dir,
    input  logic [COORD_W*NUM_ACTORS-1:0] pos_x,
    input  logic [COORD_W*NUM_ACTORS-1:0] pos_y,
    input  logic [4*NUM_ACTORS-1:0]       walls,
    output logic [3*NUM_ACTORS-1:0]       direction,
    output logic [NUM_ACTORS-1:0]         turned,
    output logic [NUM_ACTORS-1:0]         blocked
);

    for (genvar a = 0; a < NUM_ACTORS; a++) begin : g_actor
        actor_dir_unit #(
            .COORD_W    (COORD_W),
            .TILE_BITS  (TILE_BITS),
            .QUEUE_HOLD (QUEUE_HOLD)
        ) u_unit (
            .clk       (Clk),
            .rst       (Reset),
            .restart   (Restart),
            .cmd_valid (cmd_valid[a]),
            .cmd_dir   (cmd_dir[3*a +: 3]),
            .pos_x     (pos_x[COORD_W*a +: COORD_W]),
            .pos_y     (pos_y[COORD_W*a +: COORD_W]),
            .walls     (walls[4*a +: 4]),
            .direction (direction[3*a +: 3]),
            .turned    (turned[a]),
            .blocked   (blocked[a])
        );
    end

endmodule

// File: tb/tb_actor_dir_ctrl.sv
// ---------------------------------------------------------------------------
// tb_actor_dir_ctrl
// Directed scenarios plus a randomized run against a behavioural model of
// the direction rules. The DUT is built with QUEUE_HOLD = 8.
// ---------------------------------------------------------------------------
module tb_actor_dir_ctrl;

    localparam int NA   = 4;
    localparam int CW   = 10;
    localparam int TB   = 4;
    localparam int QH   = 8;
    localparam int TILE = 1 << TB;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 Restart;
    logic [NA-1:0]        cmd_valid;
    logic [3*NA-1:0]      cmd_dir;
    logic [CW*NA-1:0]     pos_x;
    logic [CW*NA-1:0]     pos_y;
    logic [4*NA-1:0]      walls;
    logic [3*NA-1:0]      direction;
    logic [NA-1:0]        turned;
    logic [NA-1:0]        blocked;

    int total = 0;
    int bad   = 0;

    // Behavioural model state, one entry per actor. Directions are plain
    // integers holding the 3-bit code value.
    int m_dir [NA];
    int m_qd  [NA];
    int m_age [NA];
    bit m_qv  [NA];
    bit m_blk [NA];
    bit m_turn[NA];

    always #5 Clk = ~Clk;

    actor_dir_ctrl #(
        .NUM_ACTORS (NA),
        .COORD_W    (CW),
        .TILE_BITS  (TB),
        .QUEUE_HOLD (QH)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Restart   (Restart),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .walls     (walls),
        .direction (direction),
        .turned    (turned),
        .blocked   (blocked)
    );

    // ---------------- model helpers ----------------
    function automatic int norm(input int raw);
        return (raw >= 4) ? raw : 0;
    endfunction

    function automatic int opp(input int d);
        case (d)
            4: return 6;
            6: return 4;
            5: return 7;
            7: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic int widx(input int d);
        case (d)
            4: return 0;
            5: return 1;
            6: return 2;
            7: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] dir_of(input int a);
        return direction[3*a +: 3];
    endfunction

    task automatic model_clear();
        for (int a = 0; a < NA; a++) begin
            m_dir[a] = 0; m_qd[a] = 0; m_age[a] = 0;
            m_qv[a] = 0; m_blk[a] = 0; m_turn[a] = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_pos(input int a, input int x, input int y);
        pos_x[CW*a +: CW] = CW'(x);
        pos_y[CW*a +: CW] = CW'(y);
    endtask

    task automatic set_walls(input int a, input logic [3:0] w);
        walls[4*a +: 4] = w;
    endtask

    task automatic send(input int a, input logic [2:0] d);
        cmd_valid[a]      = 1'b1;
        cmd_dir[3*a +: 3] = d;
    endtask

    // Advance one clock: the model computes the next state from the inputs
    // presented this cycle, then strobes are dropped after the edge.
    task automatic step();
        int nd[NA], nqd[NA], nage[NA];
        bit nqv[NA], nblk[NA], nturn[NA];
        for (int a = 0; a < NA; a++) begin
            int x, y, cd;
            bit al, mv, con;
            logic [3:0] w;
            x   = int'(pos_x[CW*a +: CW]);
            y   = int'(pos_y[CW*a +: CW]);
            w   = walls[4*a +: 4];
            cd  = norm(int'(cmd_dir[3*a +: 3]));
            al  = (x % TILE == 0) && (y % TILE == 0);
            mv  = (m_dir[a] != 0);
            con = 0;
            nd[a] = m_dir[a]; nqd[a] = m_qd[a]; nage[a] = m_age[a];
            nqv[a] = m_qv[a]; nblk[a] = m_blk[a]; nturn[a] = 0;
            if (m_qv[a] && mv && m_qd[a] == opp(m_dir[a])) begin
                nd[a] = m_qd[a]; con = 1;
            end else if (al && m_qv[a] && m_qd[a] == 0) begin
                nd[a] = 0; con = 1;
            end else if (al && m_qv[a] && m_qd[a] != 0 && !w[widx(m_qd[a])]) begin
                nd[a] = m_qd[a]; con = 1;
            end else if (al && mv && w[widx(m_dir[a])]) begin
                nd[a] = 0; nblk[a] = 1;
            end
            if (con) begin
                nturn[a] = 1; nblk[a] = 0;
            end
            if (cmd_valid[a]) begin
                nqd[a] = cd; nqv[a] = 1; nage[a] = 0;
            end else if (m_qv[a]) begin
                if (con || m_age[a] == QH - 1) nqv[a] = 0;
                nage[a] = m_age[a] + 1;
            end
            if (Restart) begin
                nd[a] = 0; nqd[a] = 0; nage[a] = 0;
                nqv[a] = 0; nblk[a] = 0; nturn[a] = 0;
            end
        end
        @(posedge Clk);
        #1;
        for (int a = 0; a < NA; a++) begin
            m_dir[a] = nd[a]; m_qd[a] = nqd[a]; m_age[a] = nage[a];
            m_qv[a] = nqv[a]; m_blk[a] = nblk[a]; m_turn[a] = nturn[a];
        end
        cmd_valid = '0;
        Restart   = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset = 1'b1; Restart = 1'b0;
        cmd_valid = '0; cmd_dir = '0; pos_x = '0; pos_y = '0; walls = '0;
        model_clear();
        #1;
        total++;
        if (direction !== '0 || turned !== '0 || blocked !== '0) begin
            bad++;
            $display("FAIL reset_state: got dir=%b turned=%b blocked=%b want all zero",
                     direction, turned, blocked);
        end
        #12 Reset = 1'b0;
        step(); step();
        total++;
        if (direction !== '0 || turned !== '0) begin
            bad++;
            $display("FAIL reset_idle: got dir=%b turned=%b want zero", direction, turned);
        end

        // Mid-run reset with a pending (wall-blocked) request.
        set_pos(0, 32, 48); set_walls(0, 4'b0000);
        send(0, 3'b101); step(); step();
        total++;
        if (dir_of(0) !== 3'b101) begin
            bad++;
            $display("FAIL reset_setup_dir: got %b want 101", dir_of(0));
        end
        set_walls(0, 4'b0001);
        send(0, 3'b100); step();
        #2 Reset = 1'b1;
        #1;
        model_clear();
        total++;
        if (direction !== '0 || turned !== '0 || blocked !== '0) begin
            bad++;
            $display("FAIL reset_async: got dir=%b turned=%b blocked=%b want all zero",
                     direction, turned, blocked);
        end
        #1 Reset = 1'b0;
        set_walls(0, 4'b0000);
        step(); step(); step();
        total++;
        if (direction !== '0 || turned !== '0) begin
            bad++;
            $display("FAIL reset_drops_queue: got dir=%b turned=%b want zero",
                     direction, turned);
        end
    endtask

    task automatic test_aligned_turn();
        set_pos(0, 32, 48); set_walls(0, 4'b0000);
        send(0, 3'b101); step(); step();
        send(0, 3'b100); step();
        total++;
        if (dir_of(0) !== 3'b101 || turned[0] !== 1'b0) begin
            bad++;
            $display("FAIL turn_n1: got dir=%b turned=%b want 101/0", dir_of(0), turned[0]);
        end
        step();
        total++;
        if (dir_of(0) !== 3'b100 || turned[0] !== 1'b1) begin
            bad++;
            $display("FAIL turn_n2: got dir=%b turned=%b want 100/1", dir_of(0), turned[0]);
        end
        step();
        total++;
        if (dir_of(0) !== 3'b100 || turned[0] !== 1'b0) begin
            bad++;
            $display("FAIL turn_n3: got dir=%b turned=%b want 100/0", dir_of(0), turned[0]);
        end
    endtask

    task automatic test_wall_stop();
        set_pos(1, 64, 32); set_walls(1, 4'b0000);
        send(1, 3'b100); step(); step();
        set_pos(1, 64, 24); step();
        set_pos(1, 64, 16); set_walls(1, 4'b0001); step();
        total++;
        if (dir_of(1) !== 3'b000 || blocked[1] !== 1'b1) begin
            bad++;
            $display("FAIL wall_stop: got dir=%b blocked=%b want 000/1", dir_of(1), blocked[1]);
        end
        send(1, 3'b111); step();
        total++;
        if (dir_of(1) !== 3'b000 || blocked[1] !== 1'b1) begin
            bad++;
            $display("FAIL wall_hold: got dir=%b blocked=%b want 000/1", dir_of(1), blocked[1]);
        end
        step();
        total++;
        if (dir_of(1) !== 3'b111 || blocked[1] !== 1'b0 || turned[1] !== 1'b1) begin
            bad++;
            $display("FAIL wall_unblock: got dir=%b blocked=%b turned=%b want 111/0/1",
                     dir_of(1), blocked[1], turned[1]);
        end
    endtask

    task automatic test_reverse_deferred();
        set_pos(0, 32, 48); set_walls(0, 4'b0000);
        send(0, 3'b101); step(); step();
        set_pos(0, 35, 48);
        send(0, 3'b111); step(); step();
        total++;
        if (dir_of(0) !== 3'b111 || turned[0] !== 1'b1) begin
            bad++;
            $display("FAIL reverse_midtile: got dir=%b turned=%b want 111/1", dir_of(0), turned[0]);
        end
        send(0, 3'b101); step(); step();
        send(0, 3'b110); step(); step();
        total++;
        if (dir_of(0) !== 3'b101) begin
            bad++;
            $display("FAIL deferred_wait35: got %b want 101", dir_of(0));
        end
        set_pos(0, 40, 48); step();
        total++;
        if (dir_of(0) !== 3'b101) begin
            bad++;
            $display("FAIL deferred_wait40: got %b want 101", dir_of(0));
        end
        set_pos(0, 48, 48); step();
        total++;
        if (dir_of(0) !== 3'b110 || turned[0] !== 1'b1) begin
            bad++;
            $display("FAIL deferred_commit: got dir=%b turned=%b want 110/1", dir_of(0), turned[0]);
        end
    endtask

    task automatic test_expiry();
        set_pos(0, 48, 48); set_walls(0, 4'b0000);
        send(0, 3'b101); step(); step();
        set_walls(0, 4'b0001);
        send(0, 3'b100); step();
        repeat (10) step();
        set_pos(0, 64, 48); set_walls(0, 4'b0000); step();
        total++;
        if (dir_of(0) !== 3'b101 || turned[0] !== 1'b0) begin
            bad++;
            $display("FAIL expiry_lapsed: got dir=%b turned=%b want 101/0", dir_of(0), turned[0]);
        end
        step();
        total++;
        if (dir_of(0) !== 3'b101) begin
            bad++;
            $display("FAIL expiry_lapsed2: got %b want 101", dir_of(0));
        end
        set_walls(0, 4'b0001);
        send(0, 3'b100); step();
        repeat (4) step();
        set_walls(0, 4'b0000); step();
        total++;
        if (dir_of(0) !== 3'b100 || turned[0] !== 1'b1) begin
            bad++;
            $display("FAIL expiry_taken: got dir=%b turned=%b want 100/1", dir_of(0), turned[0]);
        end
    endtask

    task automatic test_simultaneous();
        set_pos(2, 16, 16); set_walls(2, 4'b0000);
        send(2, 3'b100); step();
        send(2, 3'b110); step();
        total++;
        if (dir_of(2) !== 3'b100 || turned[2] !== 1'b1) begin
            bad++;
            $display("FAIL simul_consume: got dir=%b turned=%b want 100/1", dir_of(2), turned[2]);
        end
        step();
        total++;
        if (dir_of(2) !== 3'b110 || turned[2] !== 1'b1) begin
            bad++;
            $display("FAIL simul_reload: got dir=%b turned=%b want 110/1", dir_of(2), turned[2]);
        end
        set_pos(0, 80, 96); set_walls(0, 4'b0000);
        set_pos(3, 0, 0);   set_walls(3, 4'b0000);
        send(0, 3'b111); send(3, 3'b110); step(); step();
        total++;
        if (dir_of(0) !== 3'b111 || dir_of(3) !== 3'b110 || turned[0] !== 1'b1 || turned[3] !== 1'b1) begin
            bad++;
            $display("FAIL simul_two_actors: got d0=%b d3=%b turned=%b want 111/110 with bits 0,3 set",
                     dir_of(0), dir_of(3), turned);
        end
    endtask

    task automatic test_restart();
        Restart = 1'b1;
        send(1, 3'b101); step();
        total++;
        if (direction !== '0 || turned !== '0 || blocked !== '0) begin
            bad++;
            $display("FAIL restart_clear: got dir=%b turned=%b blocked=%b want all zero",
                     direction, turned, blocked);
        end
        step(); step();
        total++;
        if (dir_of(1) !== 3'b000) begin
            bad++;
            $display("FAIL restart_overrides_cmd: got %b want 000", dir_of(1));
        end
    endtask

    task automatic test_random();
        Restart = 1'b1; step();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int a = 0; a < NA; a++) begin
                int x, y;
                x = int'($urandom_range(0, 40)) * TILE;
                y = int'($urandom_range(0, 40)) * TILE;
                if ($urandom_range(0, 2) == 0) x += int'($urandom_range(1, TILE - 1));
                if ($urandom_range(0, 3) == 0) y += int'($urandom_range(1, TILE - 1));
                set_pos(a, x, y);
                set_walls(a, 4'($urandom));
                if ($urandom_range(0, 3) == 0) send(a, 3'($urandom_range(0, 7)));
            end
            if ($urandom_range(0, 99) == 0) Restart = 1'b1;
            step();
            for (int a = 0; a < NA; a++) begin
                total++;
                if (dir_of(a) !== 3'(m_dir[a]) || turned[a] !== m_turn[a] || blocked[a] !== m_blk[a]) begin
                    bad++;
                    $display("FAIL random cyc=%0d actor=%0d: got dir=%b turned=%b blocked=%b want dir=%b turned=%b blocked=%b",
                             cyc, a, dir_of(a), turned[a], blocked[a], 3'(m_dir[a]), m_turn[a], m_blk[a]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned_turn();
        test_wall_stop();
        test_reverse_deferred();
        test_expiry();
        test_simultaneous();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
